// File: rtl/alu8_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the ALU issue controller.
package alu8_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_INC   = 4'h6;
    localparam logic [3:0] OP_DEC   = 4'h7;
    localparam logic [3:0] OP_PASSA = 4'h8;
    localparam logic [3:0] OP_PASSB = 4'h9;
    localparam logic [3:0] OP_LDI   = 4'hF;

    localparam int FLAG_C  = 2;
    localparam int FLAG_OV = 1;
    localparam int FLAG_ZF = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu8_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
module alu8_regfile #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu8_issue_ctrl.sv
// Sequences instructions through an external 8-bit ALU, owns the
// register file and flag register, and emits one result beat per instruction.
module alu8_issue_ctrl
    import alu8_pkg::*;
#(
    parameter int DW     = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_dst,
    input  logic [REG_AW-1:0] instr_srca,
    input  logic [REG_AW-1:0] instr_srcb,
    input  logic [DW-1:0]     instr_imm,
    output logic [3:0]        alu_opcode,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    input  logic [DW-1:0]     alu_result,
    input  logic              alu_c,
    input  logic              alu_ov,
    input  logic              alu_zf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,
    output logic [REG_AW-1:0] res_dst,
    output logic [2:0]        res_flags,
    output logic              err
);

    state_t state_q, state_d;

    logic [3:0]        op_q;
    logic [REG_AW-1:0] dst_q, srca_q, srcb_q;
    logic [DW-1:0]     imm_q;
    logic [DW-1:0]     rd_a, rd_b;

    logic              accept, exec, is_ldi, legal, we;
    logic [DW-1:0]     wdata;
    logic [2:0]        wflags;

    logic [2:0]        flag_q;
    logic              res_ill_q;
    logic [DW-1:0]     res_data_q;
    logic [REG_AW-1:0] res_dst_q;
    logic              err_q;

    assign accept = instr_valid && instr_ready;
    assign exec   = (state_q == S_EXEC);
    assign is_ldi = (op_q == OP_LDI);
    assign legal  = (op_q <= OP_PASSB) || is_ldi;
    assign we     = exec && legal;
    assign wdata  = is_ldi ? imm_q : alu_result;

    always_comb begin
        wflags = 3'b000;
        if (is_ldi) begin
            wflags[FLAG_ZF] = (imm_q == '0);
        end else begin
            wflags[FLAG_C]  = alu_c;
            wflags[FLAG_OV] = alu_ov;
            wflags[FLAG_ZF] = alu_zf;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        alu_opcode  = OP_PASSA;
        alu_a       = '0;
        alu_b       = '0;
        unique case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_opcode = op_q;
                alu_a      = rd_a;
                alu_b      = rd_b;
                state_d    = S_RESP;
            end
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_PASSA;
            dst_q   <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= instr_op;
                dst_q  <= instr_dst;
                srca_q <= instr_srca;
                srcb_q <= instr_srcb;
                imm_q  <= instr_imm;
            end
        end
    end

    // Result registers only move in EXEC, so they hold through any RESP stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q     <= 3'b000;
            res_ill_q  <= 1'b0;
            res_data_q <= '0;
            res_dst_q  <= '0;
            err_q      <= 1'b0;
        end else if (exec) begin
            if (legal) flag_q <= wflags;
            res_ill_q  <= ~legal;
            res_data_q <= legal ? wdata : '0;
            res_dst_q  <= dst_q;
            if (!legal) err_q <= 1'b1;
        end
    end

    assign res_data  = res_data_q;
    assign res_dst   = res_dst_q;
    assign res_flags = res_ill_q ? 3'b000 : flag_q;
    assign err       = err_q;

    alu8_regfile #(
        .DW (DW),
        .AW (REG_AW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (dst_q),
        .wdata   (wdata),
        .raddr_a (srca_q),
        .rdata_a (rd_a),
        .raddr_b (srcb_q),
        .rdata_b (rd_b)
    );

endmodule

// File: tb/tb_alu8_issue_ctrl.sv
// Directed bench for alu8_issue_ctrl with a behavioural 8-bit ALU alongside.
module tb_alu8_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_dst, instr_srca, instr_srcb;
    logic [7:0] instr_imm;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       alu_c, alu_ov, alu_zf;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic [1:0] res_dst;
    logic [2:0] res_flags;
    logic       err;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu8_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst),
        .instr_srca(instr_srca), .instr_srcb(instr_srcb),
        .instr_imm(instr_imm),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_c(alu_c),
        .alu_ov(alu_ov), .alu_zf(alu_zf),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_dst(res_dst),
        .res_flags(res_flags), .err(err)
    );

    // Reference ALU: C is carry (ADD/INC) or borrow (SUB/DEC).
    logic [8:0] r9;
    logic       ov9;
    always_comb begin
        r9  = 9'd0;
        ov9 = 1'b0;
        case (alu_opcode)
            4'h0: begin
                r9  = {1'b0, alu_a} + {1'b0, alu_b};
                ov9 = (alu_a[7] == alu_b[7]) && (r9[7] != alu_a[7]);
            end
            4'h1: begin
                r9  = {1'b0, alu_a} - {1'b0, alu_b};
                ov9 = (alu_a[7] != alu_b[7]) && (r9[7] != alu_a[7]);
            end
            4'h2: r9 = {1'b0, alu_a & alu_b};
            4'h3: r9 = {1'b0, alu_a | alu_b};
            4'h4: r9 = {1'b0, alu_a ^ alu_b};
            4'h5: r9 = {1'b0, ~alu_a};
            4'h6: begin
                r9  = {1'b0, alu_a} + 9'd1;
                ov9 = (alu_a == 8'h7F);
            end
            4'h7: begin
                r9  = {1'b0, alu_a} - 9'd1;
                ov9 = (alu_a == 8'h80);
            end
            4'h8: r9 = {1'b0, alu_a};
            4'h9: r9 = {1'b0, alu_b};
            default: r9 = 9'd0;
        endcase
    end
    assign alu_result = r9[7:0];
    assign alu_c      = r9[8];
    assign alu_ov     = ov9;
    assign alu_zf     = (r9[7:0] == 8'h00);

    task automatic run_instr(
        input  logic [3:0] op, input logic [1:0] d, sa, sb,
        input  logic [7:0] imm,
        output logic [7:0] data, output logic [1:0] rdst,
        output logic [2:0] flg, output int lat,
        output logic [3:0] xop, output logic [7:0] xa, xb
    );
        bit ok;
        data = 8'hxx; rdst = 2'bxx; flg = 3'bxxx; lat = -1;
        xop = 4'hx; xa = 8'hxx; xb = 8'hxx;
        instr_op = op; instr_dst = d; instr_srca = sa;
        instr_srcb = sb; instr_imm = imm; instr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            instr_valid = 1'b0;
            $display("FAIL accept_timeout: op %h never accepted", op);
            nerr++; ncmp++;
            return;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin xop = alu_opcode; xa = alu_a; xb = alu_b; end
            if (res_valid) begin ok = 1'b1; break; end
        end
        if (!ok) lat = -1;
        data = res_data; rdst = res_dst; flg = res_flags;
        @(posedge clk); #1;
    endtask

    logic [7:0] d;
    logic [1:0] rd;
    logic [2:0] f;
    int         lat;
    logic [3:0] xop;
    logic [7:0] xa, xb;

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; res_ready = 1'b1;
        instr_op = 4'h0; instr_dst = 2'd0; instr_srca = 2'd0;
        instr_srcb = 2'd0; instr_imm = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        ncmp++; if (instr_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
        ncmp++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", res_valid); end
        ncmp++; if ({res_data, res_dst, res_flags} !== 13'd0) begin nerr++; $display("FAIL rst_res: got %h/%h/%b want 0", res_data, res_dst, res_flags); end
        ncmp++; if (err !== 1'b0) begin nerr++; $display("FAIL rst_err: got %b want 0", err); end
        ncmp++; if ({alu_opcode, alu_a, alu_b} !== {4'h8, 16'h0}) begin nerr++; $display("FAIL rst_alu: got %h %h %h want 8 00 00", alu_opcode, alu_a, alu_b); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        run_instr(4'hF, 2'd0, 2'd0, 2'd0, 8'h7F, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({d, f} !== {8'h7F, 3'b000}) begin nerr++; $display("FAIL t1_ldi0: got %h/%b want 7f/000", d, f); end
        ncmp++; if (lat !== 2) begin nerr++; $display("FAIL t1_ldi_lat: got %0d want 2", lat); end
        run_instr(4'hF, 2'd1, 2'd0, 2'd0, 8'h01, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({d, rd} !== {8'h01, 2'd1}) begin nerr++; $display("FAIL t1_ldi1: got %h/%0d want 01/1", d, rd); end
        run_instr(4'h0, 2'd2, 2'd0, 2'd1, 8'h00, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({xop, xa, xb} !== {4'h0, 8'h7F, 8'h01}) begin nerr++; $display("FAIL t1_exec_drive: got %h %h %h want 0 7f 01", xop, xa, xb); end
        ncmp++; if (d !== 8'h80) begin nerr++; $display("FAIL t1_add_data: got %h want 80", d); end
        ncmp++; if (f !== 3'b010) begin nerr++; $display("FAIL t1_add_flags: got %b want 010", f); end
        ncmp++; if (rd !== 2'd2) begin nerr++; $display("FAIL t1_add_dst: got %0d want 2", rd); end
        ncmp++; if (lat !== 2) begin nerr++; $display("FAIL t1_add_lat: got %0d want 2", lat); end
    endtask

    task automatic test_carry_zero();
        run_instr(4'hF, 2'd0, 2'd0, 2'd0, 8'hFF, d, rd, f, lat, xop, xa, xb);
        run_instr(4'h0, 2'd0, 2'd0, 2'd0, 8'h00, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({d, f} !== {8'hFE, 3'b100}) begin nerr++; $display("FAIL t2_add_ff: got %h/%b want fe/100", d, f); end
        run_instr(4'h1, 2'd3, 2'd0, 2'd0, 8'h00, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({d, f, rd} !== {8'h00, 3'b001, 2'd3}) begin nerr++; $display("FAIL t2_sub_zero: got %h/%b/%0d want 00/001/3", d, f, rd); end
    endtask

    task automatic test_backpressure();
        bit ok;
        res_ready = 1'b0;
        instr_op = 4'hF; instr_dst = 2'd2; instr_srca = 2'd0;
        instr_srcb = 2'd0; instr_imm = 8'h5A; instr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        instr_imm = 8'hA5; instr_dst = 2'd3;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
        ncmp++; if (!ok) begin nerr++; $display("FAIL t3_wait: res_valid never rose"); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            ncmp++;
            if ({res_valid, instr_ready, res_data, res_dst, res_flags} !== {1'b1, 1'b0, 8'h5A, 2'd2, 3'b000}) begin
                nerr++;
                $display("FAIL t3_hold%0d: got v%b r%b %h/%0d/%b want v1 r0 5a/2/000",
                         i, res_valid, instr_ready, res_data, res_dst, res_flags);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        ncmp++; if ({res_valid, instr_ready} !== 2'b01) begin nerr++; $display("FAIL t3_resume: got v%b r%b want v0 r1", res_valid, instr_ready); end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        ncmp++; if ({instr_ready, alu_opcode} !== {1'b0, 4'hF}) begin nerr++; $display("FAIL t3_accepted: got r%b op%h want r0 opf", instr_ready, alu_opcode); end
        @(negedge clk);
        ncmp++; if ({res_valid, res_data, res_dst} !== {1'b1, 8'hA5, 2'd3}) begin nerr++; $display("FAIL t3_second: got v%b %h/%0d want v1 a5/3", res_valid, res_data, res_dst); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        ncmp++; if (err !== 1'b0) begin nerr++; $display("FAIL t4_err_pre: got %b want 0", err); end
        run_instr(4'hF, 2'd1, 2'd0, 2'd0, 8'h55, d, rd, f, lat, xop, xa, xb);
        run_instr(4'hC, 2'd1, 2'd1, 2'd1, 8'h00, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({d, f} !== {8'h00, 3'b000}) begin nerr++; $display("FAIL t4_ill_res: got %h/%b want 00/000", d, f); end
        ncmp++; if (lat !== 2) begin nerr++; $display("FAIL t4_ill_lat: got %0d want 2", lat); end
        ncmp++; if (err !== 1'b1) begin nerr++; $display("FAIL t4_err: got %b want 1", err); end
        run_instr(4'h8, 2'd0, 2'd1, 2'd0, 8'h00, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({d, f} !== {8'h55, 3'b000}) begin nerr++; $display("FAIL t4_r1_kept: got %h/%b want 55/000", d, f); end
        ncmp++; if (err !== 1'b1) begin nerr++; $display("FAIL t4_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        run_instr(4'hF, 2'd0, 2'd0, 2'd0, 8'h11, d, rd, f, lat, xop, xa, xb);
        run_instr(4'hF, 2'd1, 2'd0, 2'd0, 8'h22, d, rd, f, lat, xop, xa, xb);
        instr_op = 4'h0; instr_dst = 2'd2; instr_srca = 2'd0;
        instr_srcb = 2'd1; instr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        ncmp++; if (alu_a !== 8'h11) begin nerr++; $display("FAIL t5_in_exec: got alu_a %h want 11", alu_a); end
        #1 rst = 1'b1;
        #2;
        ncmp++;
        if ({instr_ready, res_valid, err, res_data, res_flags} !== {3'b100, 8'h00, 3'b000}) begin
            nerr++;
            $display("FAIL t5_async: got r%b v%b e%b %h/%b want r1 v0 e0 00/000",
                     instr_ready, res_valid, err, res_data, res_flags);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ncmp++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL t5_no_beat%0d: got %b want 0", i, res_valid); end
        end
        @(posedge clk); #1;
        run_instr(4'h8, 2'd0, 2'd2, 2'd0, 8'h00, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({d, f} !== {8'h00, 3'b001}) begin nerr++; $display("FAIL t5_r2_clear: got %h/%b want 00/001", d, f); end
        run_instr(4'h9, 2'd0, 2'd0, 2'd1, 8'h00, d, rd, f, lat, xop, xa, xb);
        ncmp++; if (d !== 8'h00) begin nerr++; $display("FAIL t5_r1_clear: got %h want 00", d); end
        run_instr(4'hF, 2'd3, 2'd0, 2'd0, 8'h42, d, rd, f, lat, xop, xa, xb);
        ncmp++; if ({d, rd, f, lat} !== {8'h42, 2'd3, 3'b000, 32'd2}) begin nerr++; $display("FAIL t5_ldi_after: got %h/%0d/%b lat %0d want 42/3/000 lat 2", d, rd, f, lat); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v_op [8];
        logic [1:0] v_d [8], v_a [8], v_b [8];
        logic [7:0] v_i [8], v_exp [8];
        logic [7:0] got [8];
        int         acc [8];
        int         k, nacc, ngot;
        bit         take;
        v_op  = '{4'hF, 4'hF, 4'h0, 4'h1, 4'h4, 4'hF, 4'h3, 4'h9};
        v_d   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        v_a   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
        v_b   = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0, 2'd2};
        v_i   = '{8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
        v_exp = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h0F, 8'h2F, 8'h2F};
        k = 0; nacc = 0; ngot = 0;
        res_ready = 1'b1;
        instr_op = v_op[0]; instr_dst = v_d[0]; instr_srca = v_a[0];
        instr_srcb = v_b[0]; instr_imm = v_i[0]; instr_valid = 1'b1;
        for (int c = 0; c < 60 && ngot < 8; c++) begin
            @(negedge clk);
            if (res_valid) begin
                if (ngot < 8) got[ngot] = res_data;
                ngot++;
            end
            take = instr_ready && instr_valid;
            if (take) begin
                if (nacc < 8) acc[nacc] = c;
                nacc++;
            end
            @(posedge clk); #1;
            if (take) begin
                k++;
                if (k < 8) begin
                    instr_op = v_op[k]; instr_dst = v_d[k]; instr_srca = v_a[k];
                    instr_srcb = v_b[k]; instr_imm = v_i[k];
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        ncmp++; if (nacc !== 8 || ngot !== 8) begin nerr++; $display("FAIL t6_counts: got %0d acc %0d beats want 8 8", nacc, ngot); end
        for (int i = 0; i < 8; i++) begin
            if (i < ngot) begin
                ncmp++; if (got[i] !== v_exp[i]) begin nerr++; $display("FAIL t6_beat%0d: got %h want %h", i, got[i], v_exp[i]); end
            end
            if (i > 0 && i < nacc) begin
                ncmp++; if (acc[i] - acc[i-1] !== 3) begin nerr++; $display("FAIL t6_gap%0d: got %0d want 3", i, acc[i] - acc[i-1]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_carry_zero();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
